// File: rtl/pe_vec.sv
// Multi-lane MACC processing element: NUM_LANES lanes sharing one broadcast weight,
// with a partial-sum spill buffer and a rescale/saturate/ReLU output stage.
module pe_vec #(
  parameter int NUM_LANES         = 4,
  parameter int OP_WIDTH          = 16,
  parameter int ACC_WIDTH         = 40,
  parameter int FRAC_BITS         = 8,
  parameter int PE_BUF_ADDR_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           op_valid,
  input  logic [1:0]                     op_code,
  input  logic [NUM_LANES*OP_WIDTH-1:0]  src_0,
  input  logic [OP_WIDTH-1:0]            src_1,
  input  logic                           src_2_sel,
  input  logic [PE_BUF_ADDR_WIDTH-1:0]   buf_rd_addr,
  input  logic                           flush,
  input  logic                           write_back,
  input  logic [PE_BUF_ADDR_WIDTH-1:0]   buf_wr_addr,
  input  logic                           relu_en,
  input  logic                           pe_neuron_write_req,
  input  logic [PE_BUF_ADDR_WIDTH-1:0]   pe_neuron_write_addr,
  input  logic [NUM_LANES*ACC_WIDTH-1:0] pe_neuron_write_data,
  output logic                           out_valid,
  output logic [NUM_LANES*OP_WIDTH-1:0]  out_data,
  output logic                           sat_flag,
  output logic                           wr_conflict
);

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_MACC = 2'd1,
    OP_LOAD = 2'd2,
    OP_ADD  = 2'd3
  } op_e;

  localparam int PW    = 2 * OP_WIDTH;
  localparam int LW    = NUM_LANES * OP_WIDTH;
  localparam int BW    = NUM_LANES * ACC_WIDTH;
  localparam int DEPTH = 1 << PE_BUF_ADDR_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OP_WIDTH+1){1'b0}}, {(OP_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OP_WIDTH+1){1'b1}}, {(OP_WIDTH-1){1'b0}}};

  // S0 capture
  logic                         s0_valid_q;
  op_e                          s0_op_q;
  logic [LW-1:0]                s0_a_q;
  logic [OP_WIDTH-1:0]          s0_w_q;
  logic                         s0_sel_q;
  logic                         s0_flush_q;
  logic                         s0_wb_q;
  logic                         s0_relu_q;
  logic [PE_BUF_ADDR_WIDTH-1:0] s0_rd_addr_q;
  logic [PE_BUF_ADDR_WIDTH-1:0] s0_wr_addr_q;

  // S1 multiply
  logic                         s1_valid_q;
  op_e                          s1_op_q;
  logic [LW-1:0]                s1_a_q;
  logic [PW-1:0]                s1_prod_q [NUM_LANES];
  logic                         s1_sel_q;
  logic                         s1_flush_q;
  logic                         s1_wb_q;
  logic                         s1_relu_q;
  logic [PE_BUF_ADDR_WIDTH-1:0] s1_wr_addr_q;
  logic [BW-1:0]                s1_buf_q;
  logic [PW-1:0]                s0_prod [NUM_LANES];

  // S2 accumulate and post-process
  logic signed [ACC_WIDTH-1:0]  acc_q    [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]  acc_next [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]  lane_base;
  logic signed [ACC_WIDTH-1:0]  lane_prod;
  logic signed [ACC_WIDTH-1:0]  lane_a;
  logic signed [ACC_WIDTH-1:0]  lane_shift;
  logic [OP_WIDTH-1:0]          lane_res;
  logic                         lane_sat;
  logic [BW-1:0]                acc_next_flat;
  logic [LW-1:0]                post_flat;
  logic                         sat_any;
  logic                         op_live, close_acc, emit, spill;

  logic                         out_valid_q;
  logic [LW-1:0]                out_data_q;
  logic                         sat_q;
  logic                         wr_conflict_q;

  logic [BW-1:0]                buf_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid_q   <= 1'b0;
      s0_op_q      <= OP_NOP;
      s0_a_q       <= '0;
      s0_w_q       <= '0;
      s0_sel_q     <= 1'b0;
      s0_flush_q   <= 1'b0;
      s0_wb_q      <= 1'b0;
      s0_relu_q    <= 1'b0;
      s0_rd_addr_q <= '0;
      s0_wr_addr_q <= '0;
    end else begin
      s0_valid_q   <= op_valid;
      s0_op_q      <= op_e'(op_code);
      s0_a_q       <= src_0;
      s0_w_q       <= src_1;
      s0_sel_q     <= src_2_sel;
      s0_flush_q   <= flush;
      s0_wb_q      <= write_back;
      s0_relu_q    <= relu_en;
      s0_rd_addr_q <= buf_rd_addr;
      s0_wr_addr_q <= buf_wr_addr;
    end
  end

  // Operands are sign-extended first so the low PW bits of the product are the signed product.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      s0_prod[i] = {{OP_WIDTH{s0_a_q[i*OP_WIDTH+OP_WIDTH-1]}}, s0_a_q[i*OP_WIDTH +: OP_WIDTH]}
                 * {{OP_WIDTH{s0_w_q[OP_WIDTH-1]}}, s0_w_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_NOP;
      s1_a_q       <= '0;
      s1_sel_q     <= 1'b0;
      s1_flush_q   <= 1'b0;
      s1_wb_q      <= 1'b0;
      s1_relu_q    <= 1'b0;
      s1_wr_addr_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) s1_prod_q[i] <= '0;
    end else begin
      s1_valid_q   <= s0_valid_q;
      s1_op_q      <= s0_op_q;
      s1_a_q       <= s0_a_q;
      s1_sel_q     <= s0_sel_q;
      s1_flush_q   <= s0_flush_q;
      s1_wb_q      <= s0_wb_q;
      s1_relu_q    <= s0_relu_q;
      s1_wr_addr_q <= s0_wr_addr_q;
      for (int i = 0; i < NUM_LANES; i++) s1_prod_q[i] <= s0_prod[i];
    end
  end

  assign op_live   = s1_valid_q && (s1_op_q != OP_NOP);
  assign close_acc = op_live && s1_flush_q;
  assign emit      = close_acc && !s1_wb_q;
  assign spill     = close_acc && s1_wb_q;

  always_comb begin
    acc_next_flat = '0;
    post_flat     = '0;
    sat_any       = 1'b0;
    lane_base     = '0;
    lane_prod     = '0;
    lane_a        = '0;
    lane_shift    = '0;
    lane_res      = '0;
    lane_sat      = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_base = s1_sel_q ? s1_buf_q[i*ACC_WIDTH +: ACC_WIDTH] : acc_q[i];
      lane_prod = {{(ACC_WIDTH-PW){s1_prod_q[i][PW-1]}}, s1_prod_q[i]};
      lane_a    = {{(ACC_WIDTH-OP_WIDTH){s1_a_q[i*OP_WIDTH+OP_WIDTH-1]}},
                   s1_a_q[i*OP_WIDTH +: OP_WIDTH]};
      case (s1_op_q)
        OP_MACC: acc_next[i] = lane_base + lane_prod;
        OP_LOAD: acc_next[i] = lane_prod;
        OP_ADD:  acc_next[i] = lane_base + lane_a;
        default: acc_next[i] = acc_q[i];
      endcase
      lane_shift = acc_next[i] >>> FRAC_BITS;
      lane_sat   = 1'b1;
      if (lane_shift > SAT_MAX) begin
        lane_res = SAT_MAX[OP_WIDTH-1:0];
      end else if (lane_shift < SAT_MIN) begin
        lane_res = SAT_MIN[OP_WIDTH-1:0];
      end else begin
        lane_res = lane_shift[OP_WIDTH-1:0];
        lane_sat = 1'b0;
      end
      // ReLU runs after the clamp and never contributes to the saturation flag.
      if (s1_relu_q && lane_res[OP_WIDTH-1]) lane_res = '0;
      post_flat[i*OP_WIDTH +: OP_WIDTH]      = lane_res;
      acc_next_flat[i*ACC_WIDTH +: ACC_WIDTH] = acc_next[i];
      sat_any = sat_any | lane_sat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) acc_q[i] <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      sat_q         <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (close_acc)    acc_q[i] <= '0;
        else if (op_live) acc_q[i] <= acc_next[i];
      end
      out_valid_q <= emit;
      if (emit) out_data_q <= post_flat;
      sat_q         <= emit && sat_any;
      wr_conflict_q <= spill && pe_neuron_write_req;
    end
  end

  // Read-first buffer: the registered read sees the contents from before this edge's write.
  always_ff @(posedge clk) begin
    if (pe_neuron_write_req) buf_mem[pe_neuron_write_addr] <= pe_neuron_write_data;
    else if (spill)          buf_mem[s1_wr_addr_q]         <= acc_next_flat;
    s1_buf_q <= buf_mem[s0_rd_addr_q];
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign sat_flag    = sat_q;
  assign wr_conflict = wr_conflict_q;

endmodule
